// File: rtl/inst_mem_loadable.sv
// Loadable instruction memory for the single-cycle MIPS family.
// A word-serial load port fills the RAM and records the program length.
// The fetch port answers one request per cycle with one cycle of latency.
// Fetches that fall outside the loaded program return NOP_INST with an error flag.
// Fetches are only served in RUN; in every other state the CPU is stalled.
module inst_mem_loadable #(
  parameter int                DATA_W   = 32,
  parameter int                ADDR_W   = 8,
  parameter int                DEPTH    = 256,
  parameter logic [DATA_W-1:0] NOP_INST = 32'h00000000
) (
  input  logic              clk_i,
  input  logic              resetn_i,
  // fetch side
  input  logic              fetch_req_i,
  input  logic [ADDR_W-1:0] fetch_addr_i,
  output logic [DATA_W-1:0] fetch_inst_o,
  output logic              fetch_valid_o,
  output logic              fetch_err_o,
  output logic              fetch_stall_o,
  // load side
  input  logic              load_start_i,
  input  logic              load_we_i,
  input  logic              load_last_i,
  input  logic [DATA_W-1:0] load_data_i,
  output logic              load_done_o,
  output logic              load_ovf_o,
  output logic [ADDR_W:0]   prog_len_o
);

  // Lengths and the write pointer need one extra bit so they can hold DEPTH itself.
  localparam int               LEN_W   = ADDR_W + 1;
  localparam logic [LEN_W-1:0] DEPTH_L = LEN_W'(DEPTH);
  localparam logic [LEN_W-1:0] ONE_L   = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [LEN_W-1:0] ZERO_L  = {LEN_W{1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  // Program storage; deliberately not cleared by reset.
  logic [DATA_W-1:0] mem_q [DEPTH];

  state_t            state_q,  state_d;
  logic [LEN_W-1:0]  ptr_q,    ptr_d;
  logic [LEN_W-1:0]  len_q,    len_d;
  logic              ovf_q,    ovf_d;
  logic              done_q,   done_d;
  logic              valid_q,  valid_d;
  logic              err_q,    err_d;
  logic              stall_q,  stall_d;
  logic [DATA_W-1:0] inst_q,   inst_d;

  logic              mem_we_s;
  logic [ADDR_W-1:0] mem_wa_s;
  logic              in_range_s;

  // Unsigned, zero-extended compare of the fetch address against the loaded length.
  assign in_range_s = ({1'b0, fetch_addr_i} < len_q);

  // Next-state logic: load sequencing, overflow tracking and fetch response.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    len_d    = len_q;
    ovf_d    = ovf_q;
    done_d   = 1'b0;
    valid_d  = 1'b0;
    err_d    = 1'b0;
    inst_d   = inst_q;
    mem_we_s = 1'b0;
    mem_wa_s = ptr_q[ADDR_W-1:0];

    case (state_q)
      ST_IDLE: begin
        if (load_start_i) begin
          state_d = ST_LOAD;
          ptr_d   = ZERO_L;
          len_d   = ZERO_L;
          ovf_d   = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_LOAD: begin
        if (load_start_i) begin
          // A new start restarts the load from scratch, even mid-program.
          state_d = ST_LOAD;
          ptr_d   = ZERO_L;
          len_d   = ZERO_L;
          ovf_d   = 1'b0;
        end else if (load_we_i) begin
          if (ptr_q < DEPTH_L) begin
            mem_we_s = 1'b1;
            ptr_d    = ptr_q + ONE_L;
            len_d    = ptr_q + ONE_L;
          end else begin
            // Writes past the end are dropped; the length stays saturated at DEPTH.
            ovf_d = 1'b1;
          end
          if (load_last_i) begin
            state_d = ST_RUN;
            done_d  = 1'b1;
          end else begin
            state_d = ST_LOAD;
          end
        end else begin
          state_d = ST_LOAD;
        end
      end

      ST_RUN: begin
        if (load_start_i) begin
          // A reload wins over a simultaneous fetch; the fetch is dropped.
          state_d = ST_LOAD;
          ptr_d   = ZERO_L;
          len_d   = ZERO_L;
          ovf_d   = 1'b0;
        end else if (fetch_req_i) begin
          valid_d = 1'b1;
          if (in_range_s) begin
            inst_d = mem_q[fetch_addr_i];
            err_d  = 1'b0;
          end else begin
            inst_d = NOP_INST;
            err_d  = 1'b1;
          end
        end else begin
          state_d = ST_RUN;
        end
      end

      default: begin
        state_d = ST_IDLE;
        ptr_d   = ZERO_L;
        len_d   = ZERO_L;
        ovf_d   = 1'b0;
      end
    endcase

    stall_d = (state_d != ST_RUN);
  end

  // Control and output registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      state_q <= ST_IDLE;
      ptr_q   <= ZERO_L;
      len_q   <= ZERO_L;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      stall_q <= 1'b1;
      inst_q  <= NOP_INST;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      len_q   <= len_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      stall_q <= stall_d;
      inst_q  <= inst_d;
    end
  end

  // RAM write port; a write coinciding with reset is suppressed.
  always_ff @(posedge clk_i) begin
    if (resetn_i && mem_we_s) begin
      mem_q[mem_wa_s] <= load_data_i;
    end
  end

  assign fetch_inst_o  = inst_q;
  assign fetch_valid_o = valid_q;
  assign fetch_err_o   = err_q;
  assign fetch_stall_o = stall_q;
  assign load_done_o   = done_q;
  assign load_ovf_o    = ovf_q;
  assign prog_len_o    = len_q;

endmodule

// File: tb/tb_inst_mem_loadable.sv
// Directed bench for inst_mem_loadable with a small DEPTH so overflow is reachable.
// A behavioural model tracks the program contents and length and is checked every cycle.
module tb_inst_mem_loadable;

  localparam int          DW  = 32;
  localparam int          AW  = 8;
  localparam int          DEP = 4;
  localparam logic [31:0] NOP = 32'h00000000;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          fetch_req = 1'b0;
  logic [AW-1:0] fetch_addr = '0;
  logic [DW-1:0] fetch_inst;
  logic          fetch_valid, fetch_err, fetch_stall;
  logic          load_start = 1'b0, load_we = 1'b0, load_last = 1'b0;
  logic [DW-1:0] load_data = '0;
  logic          load_done, load_ovf;
  logic [AW:0]   prog_len;

  inst_mem_loadable #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEP), .NOP_INST(NOP)) dut (
    .clk_i(clk), .resetn_i(resetn),
    .fetch_req_i(fetch_req), .fetch_addr_i(fetch_addr), .fetch_inst_o(fetch_inst),
    .fetch_valid_o(fetch_valid), .fetch_err_o(fetch_err), .fetch_stall_o(fetch_stall),
    .load_start_i(load_start), .load_we_i(load_we), .load_last_i(load_last),
    .load_data_i(load_data), .load_done_o(load_done), .load_ovf_o(load_ovf),
    .prog_len_o(prog_len)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int done_count = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Behavioural model: a program is a list of words plus a length; the block is idle, loading or running.
  int          m_mode = 0;       // 0 idle, 1 loading, 2 running
  int          m_len = 0;
  logic [31:0] m_prog [256];
  logic        m_valid, m_err, m_done, m_ovf;
  logic [31:0] m_inst;
  bit          armed = 1'b0;

  always @(posedge clk) begin
    if (!resetn) begin
      m_mode = 0; m_len = 0; m_valid = 1'b0; m_err = 1'b0;
      m_done = 1'b0; m_ovf = 1'b0; m_inst = NOP; armed = 1'b1;
    end else if (armed) begin
      m_valid = 1'b0; m_err = 1'b0; m_done = 1'b0;
      if (load_start) begin
        m_mode = 1; m_len = 0; m_ovf = 1'b0;
      end else if (m_mode == 1 && load_we) begin
        if (m_len < DEP) begin
          m_prog[m_len] = load_data;
          m_len = m_len + 1;
        end else begin
          m_ovf = 1'b1;
        end
        if (load_last) begin
          m_mode = 2; m_done = 1'b1;
        end
      end else if (m_mode == 2 && fetch_req) begin
        m_valid = 1'b1;
        if (int'(fetch_addr) < m_len) begin
          m_inst = m_prog[fetch_addr];
        end else begin
          m_inst = NOP; m_err = 1'b1;
        end
      end
    end
    #1;
    if (armed) begin
      chk("valid", fetch_valid, m_valid);
      chk("stall", fetch_stall, (m_mode != 2));
      chk("done", load_done, m_done);
      chk("ovf", load_ovf, m_ovf);
      chk("prog_len", prog_len, 64'(m_len));
      chk("inst", fetch_inst, m_inst);
      if (m_valid) chk("err", fetch_err, m_err);
      if (load_done === 1'b1) done_count++;
    end
  end

  // Drive one cycle's inputs on the falling edge.
  task automatic step(input logic rn, input logic ls, input logic we, input logic last,
                      input logic [31:0] d, input logic fr, input logic [7:0] a);
    @(negedge clk);
    resetn = rn; load_start = ls; load_we = we; load_last = last;
    load_data = d; fetch_req = fr; fetch_addr = a;
  endtask

  task automatic idle();
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 8'd0);
  endtask

  task automatic word(input logic [31:0] d, input logic last);
    step(1'b1, 1'b0, 1'b1, last, d, 1'b0, 8'd0);
  endtask

  task automatic fetch(input logic [7:0] a);
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, a);
  endtask

  task automatic start();
    step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 8'd0);
  endtask

  initial begin
    // reset and reset-state literals
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 8'd0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 8'd0);
    idle();
    chk("rst_stall", fetch_stall, 1'b1);
    chk("rst_valid", fetch_valid, 1'b0);
    chk("rst_len", prog_len, 9'd0);
    chk("rst_inst", fetch_inst, 32'h0);
    chk("rst_ovf", load_ovf, 1'b0);

    // fetches before any load are ignored
    fetch(8'd0);
    fetch(8'd0);
    chk("idle_fetch_valid", fetch_valid, 1'b0);
    fetch(8'd0);
    chk("idle_fetch_stall", fetch_stall, 1'b1);
    idle();
    chk("idle_fetch_inst", fetch_inst, 32'h0);

    // three-word program
    start();
    word(32'h24020001, 1'b0);
    word(32'h24030001, 1'b0);
    word(32'h24040001, 1'b1);
    idle();
    chk("load3_done", load_done, 1'b1);
    chk("load3_len", prog_len, 9'd3);
    chk("load3_stall", fetch_stall, 1'b0);
    idle();
    chk("load3_done_pulse", load_done, 1'b0);

    // back-to-back fetches, then out-of-range boundaries
    fetch(8'd0);
    fetch(8'd1);
    chk("f0_inst", fetch_inst, 32'h24020001);
    chk("f0_valid", fetch_valid, 1'b1);
    fetch(8'd2);
    chk("f1_inst", fetch_inst, 32'h24030001);
    fetch(8'd3);
    chk("f2_inst", fetch_inst, 32'h24040001);
    chk("f2_err", fetch_err, 1'b0);
    fetch(8'd255);
    chk("f3_inst", fetch_inst, NOP);
    chk("f3_err", fetch_err, 1'b1);
    chk("f3_valid", fetch_valid, 1'b1);
    fetch(8'd2);
    chk("f255_err", fetch_err, 1'b1);
    idle();
    idle();
    chk("hold_valid", fetch_valid, 1'b0);
    chk("hold_inst", fetch_inst, 32'h24040001);

    // load_we outside LOAD has no effect
    word(32'hDEADBEEF, 1'b1);
    idle();
    chk("run_we_len", prog_len, 9'd3);
    chk("run_we_done", load_done, 1'b0);

    // overflow: six words into a four-word memory
    start();
    for (int i = 0; i < 6; i++) word(32'hA0000000 + 32'(i), (i == 5));
    idle();
    chk("ovf_flag", load_ovf, 1'b1);
    chk("ovf_len", prog_len, 9'd4);
    chk("ovf_stall", fetch_stall, 1'b0);
    for (int i = 0; i < 5; i++) fetch(8'(i));
    idle();
    chk("ovf_f4_err", fetch_err, 1'b1);

    // reload wins over a simultaneous fetch; start beats load_we
    step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 8'd0);
    idle();
    chk("restart_valid", fetch_valid, 1'b0);
    chk("restart_stall", fetch_stall, 1'b1);
    chk("restart_len", prog_len, 9'd0);
    chk("restart_ovf", load_ovf, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b1, 32'hBAD0BAD0, 1'b0, 8'd0);
    idle();
    chk("prio_len", prog_len, 9'd0);
    chk("prio_stall", fetch_stall, 1'b1);
    word(32'h12345678, 1'b1);
    idle();
    chk("reload_len", prog_len, 9'd1);
    fetch(8'd0);
    idle();
    chk("reload_inst", fetch_inst, 32'h12345678);

    // reset in the middle of a load
    start();
    word(32'h11111111, 1'b0);
    word(32'h22222222, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 32'h33333333, 1'b0, 8'd0);
    idle();
    chk("midrst_len", prog_len, 9'd0);
    chk("midrst_stall", fetch_stall, 1'b1);
    word(32'h44444444, 1'b0);
    word(32'h55555555, 1'b1);
    idle();
    chk("midrst_done", load_done, 1'b0);
    fetch(8'd0);
    idle();
    chk("midrst_fetch", fetch_valid, 1'b0);
    idle();
    chk("done_pulses", done_count, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/inst_mem_loadable.md
Name: inst_mem_loadable

Overview:
- Parametrised, synchronous-read instruction memory for the MIPS single-cycle CPU family.
- Replaces the fixed, hard-coded instruction table with a RAM that is filled at run time through a word-serial load port.
- Fetch side: request/valid handshake with 1-cycle latency, length tracking, and an out-of-range error flag.
- Sits between the test harness/loader and the CPU fetch stage. The CPU must hold the PC while fetch_stall is high.

Parameters:
- DATA_W, 32, instruction word width in bits.
- ADDR_W, 8, word-address width.
- DEPTH, 256, number of words; must satisfy 1 <= DEPTH <= 2^ADDR_W.
- NOP_INST, 32'h00000000, word returned for invalid fetches.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- resetn  in  1  synchronous, active-low reset.
- fetch_req  in  1  fetch request, one word per cycle.
- fetch_addr  in  ADDR_W  word address (byte PC >> 2).
- fetch_inst  out  DATA_W  fetched instruction.
- fetch_valid  out  1  fetch_inst/fetch_err valid this cycle.
- fetch_err  out  1  the valid fetch was out of range (addr >= prog_len).
- fetch_stall  out  1  high whenever state != RUN.
- load_start  in  1  begin a new program load.
- load_we  in  1  load_data is valid this cycle.
- load_last  in  1  qualifies load_we: final word of the program.
- load_data  in  DATA_W  program word.
- load_done  out  1  one-cycle pulse when the load completes.
- load_ovf  out  1  sticky: a write was attempted beyond DEPTH.
- prog_len  out  ADDR_W+1  number of words loaded.

Behaviour:
- Reset: synchronous, active-low; the polarity and synchronicity are fixed for this block. When resetn is low at a clock edge:
  - state <= IDLE; prog_len, write pointer, fetch_valid, fetch_err, load_done and load_ovf <= 0.
  - fetch_inst <= NOP_INST; fetch_stall = 1.
  - RAM contents are not cleared, but they are unreachable because prog_len = 0.
- States: IDLE, LOAD, RUN.
  - IDLE -> LOAD on load_start.
  - RUN -> LOAD on load_start.
  - LOAD -> RUN on load_we && load_last.
  - load_start while in LOAD restarts the load: pointer <= 0, prog_len <= 0, load_ovf <= 0.
- Entering LOAD: write pointer <= 0, prog_len <= 0, load_ovf <= 0.
- In LOAD, on load_we:
  - If pointer < DEPTH: mem[pointer] <= load_data; pointer++; prog_len <= pointer+1.
  - Otherwise: the write is dropped and load_ovf <= 1.
- Last word: load_we && load_last also performs its write (if in range), sets state <= RUN, and pulses load_done for one cycle (the cycle after the edge).
- load_we outside LOAD is ignored. load_last without load_we is ignored. load_start has priority over load_we in the same cycle.
- Fetch, in RUN with fetch_req = 1 at edge N, the outputs at edge N+1 are:
  - fetch_valid = 1.
  - If fetch_addr < prog_len: fetch_inst = mem[fetch_addr], fetch_err = 0.
  - Otherwise: fetch_inst = NOP_INST, fetch_err = 1.
- Back-to-back requests give one result per cycle. With fetch_req = 0, fetch_valid = 0 next cycle and fetch_inst holds its last value.
- fetch_req outside RUN is ignored; no valid is produced.
- fetch_req and load_start in the same RUN cycle: load_start wins, the fetch is dropped, and fetch_valid = 0 next cycle.
- Read-during-load hazard cannot occur, because fetches are gated to RUN only.
- Width rules:
  - The compare is unsigned, ADDR_W+1 bits wide (zero-extended fetch_addr versus prog_len).
  - prog_len saturates at DEPTH.
- Reset mid-load: the partial program is discarded (prog_len = 0) and the block returns to IDLE; a fresh load_start is required.

Test Plan:
- Reset, then drive fetch_req=1 with fetch_addr=0 for 3 cycles -> fetch_valid stays 0, fetch_stall=1, fetch_inst=32'h0.
- Load 3 words 32'h24020001, 32'h24030001, 32'h24040001 (load_last on the 3rd) -> load_done pulses once, prog_len=3, fetch_stall=0. Then fetch addrs 0,1,2 back-to-back -> the same words on consecutive cycles with fetch_valid=1, fetch_err=0.
- After the above load, fetch addr 3 -> fetch_inst=NOP_INST, fetch_err=1, fetch_valid=1.
- DEPTH=4: write 6 words, last flagged -> load_ovf=1, prog_len=4, mem[0..3] hold words 0..3, state RUN.
- In RUN, assert load_start with fetch_req in the same cycle -> no fetch_valid next cycle, fetch_stall=1, prog_len=0. Reload 1 word -> fetch addr 0 returns the new word.
- Pull resetn low for 1 cycle after 2 of 5 load words -> state IDLE, prog_len=0, load_done never pulses, subsequent fetches ignored.
